// File: rtl/pause_pkg.sv
// Shared definitions for the pause/dim controller.
//   - Dim-timer state encoding (IDLE / COUNT / DIM).
//   - Bit positions inside the 2-bit `options` vector.
package pause_pkg;

  typedef logic [1:0] dim_state_t;

  localparam dim_state_t ST_IDLE  = 2'd0;  // not counting, counters held at 0
  localparam dim_state_t ST_COUNT = 2'd1;  // paused and dim enabled, counting seconds
  localparam dim_state_t ST_DIM   = 2'd2;  // delay elapsed, video dimmed

  localparam int OPT_OSD = 0;  // pause while OSD is open
  localparam int OPT_DIM = 1;  // dim the picture after a long pause

endpackage

// File: rtl/pause_dimmer.sv
// Registered video pass-through with optional per-channel dimming.
// Each colour channel is shifted right independently, so no bits leak
// from one channel into the next, and the vacated MSBs are zero-filled.
//   clk_sys : system clock
//   reset_n : asynchronous active-low reset, clears the output register
//   i_dim   : apply the dimming shift this cycle
//   i_rgb   : {R,G,B} from the core
//   o_rgb   : {R,G,B} to the video path, one cycle later
module pause_dimmer #(
  parameter int RW        = 2,
  parameter int GW        = 2,
  parameter int BW        = 2,
  parameter int DIM_SHIFT = 1
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                i_dim,
  input  logic [RW+GW+BW-1:0] i_rgb,
  output logic [RW+GW+BW-1:0] o_rgb
);

  localparam int W = RW + GW + BW;

  logic [RW-1:0] w_r;
  logic [GW-1:0] w_g;
  logic [BW-1:0] w_b;
  logic [W-1:0]  w_dimmed;
  logic [W-1:0]  r_rgb;

  assign w_r = i_rgb[W-1 -: RW];
  assign w_g = i_rgb[BW +: GW];
  assign w_b = i_rgb[0 +: BW];

  // Each shift is self-determined at its channel width, which gives the
  // zero-filled MSBs without any cross-channel carry.
  assign w_dimmed = {w_r >> DIM_SHIFT, w_g >> DIM_SHIFT, w_b >> DIM_SHIFT};

  // NOTE: registered state is always assigned with <= so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= i_dim ? w_dimmed : i_rgb;
    end
  end

  assign o_rgb = r_rgb;

endmodule

// File: rtl/pause_ctrl.sv
// Pause and screen-dim controller for arcade cores.
// Merges the user pause toggle, the OSD and NREQ system requests into one
// registered CPU halt, then dims the picture after DIM_SEC paused seconds.
//   clk_sys       : system clock
//   reset_n       : asynchronous active-low reset
//   user_button   : pause button level (already in clk_sys domain)
//   pause_request : NREQ active-high system pause requests
//   OSD_STATUS    : OSD open level
//   options       : [0] pause while OSD open, [1] dim enable
//   rgb_in        : {R,G,B} from the core
//   rgb_out       : {R,G,B} to video, possibly dimmed
//   pause_cpu     : halt the core
//   dim_active    : video currently dimmed
//   user_paused   : user toggle latch state
module pause_ctrl
  import pause_pkg::*;
#(
  parameter int RW          = 2,
  parameter int GW          = 2,
  parameter int BW          = 2,
  parameter int CLKSPD      = 11,
  parameter int TICK_CYCLES = CLKSPD * 1000000,
  parameter int NREQ        = 1,
  parameter int DIM_SEC     = 10,
  parameter int DIM_SHIFT   = 1
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                user_button,
  input  logic [NREQ-1:0]     pause_request,
  input  logic                OSD_STATUS,
  input  logic [1:0]          options,
  input  logic [RW+GW+BW-1:0] rgb_in,
  output logic [RW+GW+BW-1:0] rgb_out,
  output logic                pause_cpu,
  output logic                dim_active,
  output logic                user_paused
);

  // A one-cycle tick period would give a zero-width prescaler; keep one bit.
  localparam int             PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [7:0]     SEC_LAST   = 8'(DIM_SEC - 1);

  logic          r_btn_sync;
  logic          r_btn_prev;
  logic          r_user_paused;
  logic          r_pause;
  logic          r_dim;
  dim_state_t    r_state;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_sec;

  logic          w_btn_rise;
  logic          w_pause_next;
  logic          w_dim_en;

  assign w_btn_rise   = r_btn_sync & ~r_btn_prev;
  assign w_pause_next = r_user_paused | (|pause_request)
                      | (options[OPT_OSD] & OSD_STATUS);
  assign w_dim_en     = options[OPT_DIM];

  // Button sampling, toggle latch and merged halt. History resets to 0 so a
  // button held through reset counts as one press on the first sample.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_sync    <= 1'b0;
      r_btn_prev    <= 1'b0;
      r_user_paused <= 1'b0;
      r_pause       <= 1'b0;
    end else begin
      r_btn_sync    <= user_button;
      r_btn_prev    <= r_btn_sync;
      r_user_paused <= r_user_paused ^ w_btn_rise;
      r_pause       <= w_pause_next;
    end
  end

  // Dim timer. Leaving COUNT or DIM always clears the counters and drops
  // dim_active on the same edge, so a re-pause starts a full delay again.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_sec   <= '0;
      r_dim   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_presc <= '0;
          r_sec   <= '0;
          r_dim   <= 1'b0;
          if (r_pause && w_dim_en) r_state <= ST_COUNT;
        end
        ST_COUNT: begin
          if (!r_pause || !w_dim_en) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_sec   <= '0;
            r_dim   <= 1'b0;
          end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
            r_sec   <= r_sec + 8'd1;
            // Last second completing: the counter lands on DIM_SEC and
            // stays there while frozen in DIM.
            if (r_sec == SEC_LAST) begin
              r_state <= ST_DIM;
              r_dim   <= 1'b1;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        ST_DIM: begin
          if (!r_pause || !w_dim_en) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_sec   <= '0;
            r_dim   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_presc <= '0;
          r_sec   <= '0;
          r_dim   <= 1'b0;
        end
      endcase
    end
  end

  pause_dimmer #(
    .RW        (RW),
    .GW        (GW),
    .BW        (BW),
    .DIM_SHIFT (DIM_SHIFT)
  ) u_dimmer (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_dim   (r_dim),
    .i_rgb   (rgb_in),
    .o_rgb   (rgb_out)
  );

  assign pause_cpu   = r_pause;
  assign dim_active  = r_dim;
  assign user_paused = r_user_paused;

endmodule

// File: tb/tb_pause_ctrl.sv
// Self-checking bench for pause_ctrl: directed scenarios plus a randomized
// run, all compared against a behavioural model that tracks how long the
// controller has been continuously paused with dimming enabled.
module tb_pause_ctrl;

  localparam int RW      = 2;
  localparam int GW      = 2;
  localparam int BW      = 2;
  localparam int W       = RW + GW + BW;
  localparam int NREQ    = 2;
  localparam int TICKS   = 4;
  localparam int DSEC    = 3;
  localparam int DSH     = 1;
  localparam int DIM_CYC = DSEC * TICKS;

  logic            clk_sys       = 1'b0;
  logic            reset_n       = 1'b0;
  logic            user_button   = 1'b0;
  logic [NREQ-1:0] pause_request = '0;
  logic            OSD_STATUS    = 1'b0;
  logic [1:0]      options       = 2'b00;
  logic [W-1:0]    rgb_in        = '0;
  logic [W-1:0]    rgb_out;
  logic            pause_cpu;
  logic            dim_active;
  logic            user_paused;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  pause_ctrl #(
    .RW          (RW),
    .GW          (GW),
    .BW          (BW),
    .CLKSPD      (11),
    .TICK_CYCLES (TICKS),
    .NREQ        (NREQ),
    .DIM_SEC     (DSEC),
    .DIM_SHIFT   (DSH)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .user_button   (user_button),
    .pause_request (pause_request),
    .OSD_STATUS    (OSD_STATUS),
    .options       (options),
    .rgb_in        (rgb_in),
    .rgb_out       (rgb_out),
    .pause_cpu     (pause_cpu),
    .dim_active    (dim_active),
    .user_paused   (user_paused)
  );

  // ---------------- reference model ----------------
  // m_run counts consecutive edges on which the halt was high with dimming
  // enabled; the picture is dimmed once that run exceeds DSEC seconds.
  logic         m_sync, m_prev, m_up, m_pause, m_dim;
  logic [W-1:0] m_rgb;
  int           m_run;

  function automatic logic [W-1:0] dim_of(input logic [W-1:0] c);
    logic [RW-1:0] r;
    logic [GW-1:0] g;
    logic [BW-1:0] b;
    r = c[W-1 -: RW];
    g = c[BW +: GW];
    b = c[0 +: BW];
    return {r >> DSH, g >> DSH, b >> DSH};
  endfunction

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_sync  <= 1'b0;
      m_prev  <= 1'b0;
      m_up    <= 1'b0;
      m_pause <= 1'b0;
      m_dim   <= 1'b0;
      m_rgb   <= '0;
      m_run   <= 0;
    end else begin
      m_sync  <= user_button;
      m_prev  <= m_sync;
      m_up    <= m_up ^ (m_sync & ~m_prev);
      m_pause <= m_up | (|pause_request) | (options[0] & OSD_STATUS);
      m_run   <= (m_pause && options[1]) ? m_run + 1 : 0;
      m_dim   <= (m_pause && options[1]) && (m_run + 1 > DIM_CYC);
      m_rgb   <= m_dim ? dim_of(rgb_in) : rgb_in;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n       = 1'b0;
    rgb_in        = 6'h3F;
    options       = 2'b11;
    OSD_STATUS    = 1'b1;
    pause_request = '1;
    repeat (3) @(negedge clk_sys);
    n_tests++; if (rgb_out !== 6'h00) begin n_fail++; $display("FAIL reset_rgb got %h want 00", rgb_out); end
    n_tests++; if (pause_cpu !== 1'b0) begin n_fail++; $display("FAIL reset_pause got %b want 0", pause_cpu); end
    n_tests++; if (dim_active !== 1'b0) begin n_fail++; $display("FAIL reset_dim got %b want 0", dim_active); end
    n_tests++; if (user_paused !== 1'b0) begin n_fail++; $display("FAIL reset_user got %b want 0", user_paused); end
    options       = 2'b00;
    OSD_STATUS    = 1'b0;
    pause_request = '0;
    reset_n       = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_button();
    int first1 = -1;
    int first2 = -1;
    options = 2'b00;
    for (int i = 0; i < 40; i++) begin
      user_button = (i < 5) || (i >= 25 && i < 30);
      @(negedge clk_sys);
      n_tests++;
      if ({pause_cpu, dim_active, user_paused, rgb_out} !== {m_pause, m_dim, m_up, m_rgb}) begin
        n_fail++;
        $display("FAIL button cyc %0d got %b want %b", i,
                 {pause_cpu, dim_active, user_paused, rgb_out}, {m_pause, m_dim, m_up, m_rgb});
      end
      if (i < 25 && pause_cpu && first1 < 0) first1 = i + 1;
      if (i >= 25 && !pause_cpu && first2 < 0) first2 = i - 24;
    end
    n_tests++; if (first1 !== 3) begin n_fail++; $display("FAIL button_press_latency got %0d want 3", first1); end
    n_tests++; if (first2 !== 3) begin n_fail++; $display("FAIL button_release_latency got %0d want 3", first2); end
    n_tests++; if (user_paused !== 1'b0) begin n_fail++; $display("FAIL button_two_toggles got %b want 0", user_paused); end
  endtask

  task automatic test_merge();
    options = 2'b00;
    for (int i = 0; i < 30; i++) begin
      user_button      = (i < 3) || (i >= 12 && i < 15);
      pause_request[1] = (i >= 8 && i < 22);
      @(negedge clk_sys);
      n_tests++;
      if ({pause_cpu, dim_active, user_paused, rgb_out} !== {m_pause, m_dim, m_up, m_rgb}) begin
        n_fail++;
        $display("FAIL merge cyc %0d got %b want %b", i,
                 {pause_cpu, dim_active, user_paused, rgb_out}, {m_pause, m_dim, m_up, m_rgb});
      end
      if (i == 20) begin
        n_tests++; if (pause_cpu !== 1'b1) begin n_fail++; $display("FAIL merge_held got %b want 1", pause_cpu); end
        n_tests++; if (user_paused !== 1'b0) begin n_fail++; $display("FAIL merge_user_off got %b want 0", user_paused); end
      end
      if (i == 22) begin
        n_tests++; if (pause_cpu !== 1'b0) begin n_fail++; $display("FAIL merge_drop got %b want 0", pause_cpu); end
      end
    end
  endtask

  task automatic test_osd();
    for (int i = 0; i < 10; i++) begin
      OSD_STATUS = (i < 6);
      options    = (i >= 3 && i < 6) ? 2'b01 : 2'b00;
      @(negedge clk_sys);
      n_tests++;
      if ({pause_cpu, dim_active, user_paused, rgb_out} !== {m_pause, m_dim, m_up, m_rgb}) begin
        n_fail++;
        $display("FAIL osd cyc %0d got %b want %b", i,
                 {pause_cpu, dim_active, user_paused, rgb_out}, {m_pause, m_dim, m_up, m_rgb});
      end
      if (i == 2) begin
        n_tests++; if (pause_cpu !== 1'b0) begin n_fail++; $display("FAIL osd_gated got %b want 0", pause_cpu); end
      end
      if (i == 3) begin
        n_tests++; if (pause_cpu !== 1'b1) begin n_fail++; $display("FAIL osd_enabled got %b want 1", pause_cpu); end
      end
    end
  endtask

  task automatic test_dim();
    int p = -1;
    int d = -1;
    int q = -1;
    options = 2'b10;
    rgb_in  = 6'b11_10_01;
    for (int i = 0; i < 40 && (d < 0 || i <= d + 2); i++) begin
      user_button = (i < 3);
      @(negedge clk_sys);
      n_tests++;
      if ({pause_cpu, dim_active, user_paused, rgb_out} !== {m_pause, m_dim, m_up, m_rgb}) begin
        n_fail++;
        $display("FAIL dim cyc %0d got %b want %b", i,
                 {pause_cpu, dim_active, user_paused, rgb_out}, {m_pause, m_dim, m_up, m_rgb});
      end
      if (pause_cpu && p < 0) p = i;
      if (dim_active && d < 0) d = i;
      if (d >= 0 && i == d + 1) begin
        n_tests++; if (rgb_out !== 6'b01_01_00) begin n_fail++; $display("FAIL dim_rgb got %b want 010100", rgb_out); end
      end
    end
    n_tests++;
    if (p < 0 || d < 0 || (d - p) < DIM_CYC - 1 || (d - p) > DIM_CYC + 1) begin
      n_fail++; $display("FAIL dim_delay got %0d want %0d+-1", d - p, DIM_CYC);
    end
    // Unpause with a second button press.
    for (int i = 0; i < 20 && q < 0; i++) begin
      user_button = (i < 3);
      @(negedge clk_sys);
      if (!pause_cpu) q = i;
    end
    user_button = 1'b0;
    n_tests++; if (q < 0) begin n_fail++; $display("FAIL undim_timeout got none want pause_cpu low"); end
    repeat (2) @(negedge clk_sys);
    n_tests++; if (dim_active !== 1'b0) begin n_fail++; $display("FAIL undim_flag got %b want 0", dim_active); end
    n_tests++; if (rgb_out !== 6'b11_10_01) begin n_fail++; $display("FAIL undim_rgb got %b want 111001", rgb_out); end
  endtask

  task automatic test_dim_disable();
    int p = -1;
    int r = -1;
    int d = -1;
    options = 2'b10;
    for (int i = 0; i < 60 && d < 0; i++) begin
      user_button = (i < 3);
      if (p >= 0 && i == p + 8)  options = 2'b00;
      if (p >= 0 && i == p + 11) begin options = 2'b10; r = i; end
      @(negedge clk_sys);
      n_tests++;
      if ({pause_cpu, dim_active, user_paused, rgb_out} !== {m_pause, m_dim, m_up, m_rgb}) begin
        n_fail++;
        $display("FAIL dim_disable cyc %0d got %b want %b", i,
                 {pause_cpu, dim_active, user_paused, rgb_out}, {m_pause, m_dim, m_up, m_rgb});
      end
      if (pause_cpu && p < 0) p = i;
      if (dim_active && d < 0) d = i;
    end
    n_tests++;
    if (r < 0 || d < 0 || (d - r) < DIM_CYC || (d - r) > DIM_CYC + 2) begin
      n_fail++; $display("FAIL dim_restart got %0d want %0d..%0d", d - r, DIM_CYC, DIM_CYC + 2);
    end
    // Leave the user latch cleared for the next scenario.
    for (int i = 0; i < 8; i++) begin
      user_button = (i < 3);
      @(negedge clk_sys);
    end
    user_button = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39, 0) == 0) user_button = ~user_button;
      for (int k = 0; k < NREQ; k++)
        if ($urandom_range(59, 0) == 0) pause_request[k] = ~pause_request[k];
      if ($urandom_range(49, 0) == 0) OSD_STATUS = ~OSD_STATUS;
      if ($urandom_range(99, 0) == 0) options[0] = ~options[0];
      if ($urandom_range(99, 0) == 0) options[1] = ~options[1];
      rgb_in = W'($urandom);
      @(negedge clk_sys);
      n_tests++;
      if ({pause_cpu, dim_active, user_paused, rgb_out} !== {m_pause, m_dim, m_up, m_rgb}) begin
        n_fail++;
        $display("FAIL random cyc %0d got %b want %b", i,
                 {pause_cpu, dim_active, user_paused, rgb_out}, {m_pause, m_dim, m_up, m_rgb});
      end
    end
  endtask

  task automatic test_reset_mid_dim();
    int d = -1;
    options       = 2'b10;
    pause_request = 2'b01;
    rgb_in        = 6'h3F;
    for (int i = 0; i < 40 && d < 0; i++) begin
      @(negedge clk_sys);
      if (dim_active) d = i;
    end
    n_tests++; if (d < 0) begin n_fail++; $display("FAIL middim_reach got none want dim_active"); end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({pause_cpu, dim_active, user_paused, rgb_out} !== '0) begin
      n_fail++; $display("FAIL middim_async got %b want 0", {pause_cpu, dim_active, user_paused, rgb_out});
    end
    user_button   = 1'b0;
    pause_request = '0;
    options       = 2'b00;
    OSD_STATUS    = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      n_tests++;
      if ({pause_cpu, dim_active, user_paused, rgb_out} !== {m_pause, m_dim, m_up, m_rgb}) begin
        n_fail++;
        $display("FAIL middim_after cyc %0d got %b want %b", i,
                 {pause_cpu, dim_active, user_paused, rgb_out}, {m_pause, m_dim, m_up, m_rgb});
      end
    end
  endtask

  initial begin
    @(negedge clk_sys);
    test_reset();
    test_button();
    test_merge();
    test_osd();
    test_dim();
    test_dim_disable();
    test_random();
    test_reset_mid_dim();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pause_ctrl.md
# pause_ctrl

Parametrised pause and screen-dim controller for arcade cores; successor to the fixed three-input pause block. It merges N pause sources (user button toggle, OSD open, any number of system requests such as hiscore load/save) into one registered CPU halt. While paused it counts wall-clock seconds and, after a configurable delay, dims the video path by a configurable shift. It sits between the core's RGB output and `arcade_video`, and drives the core's pause/halt input.

## Interface
Parameters:
- `RW`, 2, red channel width in bits
- `GW`, 2, green channel width in bits
- `BW`, 2, blue channel width in bits
- `CLKSPD`, 11, clk_sys frequency in MHz
- `TICK_CYCLES`, CLKSPD*1000000, clk_sys cycles per dim-timer second (overridable for simulation)
- `NREQ`, 1, number of system pause request inputs (≥1)
- `DIM_SEC`, 10, paused seconds before dimming (1..255)
- `DIM_SHIFT`, 1, right-shift applied to each colour channel when dimmed (0..min width)

Ports:
- `clk_sys` in 1 system clock
- `reset_n` in 1 reset; one clock; reset is asynchronous and active-low
- `user_button` in 1 pause button, level, asynchronous to nothing (already in clk_sys domain)
- `pause_request` in NREQ system pause requests, level, active-high
- `OSD_STATUS` in 1 OSD open, level
- `options` in 2 bit0 = pause while OSD open enable, bit1 = dim enable
- `rgb_in` in RW+GW+BW {R,G,B} from core
- `rgb_out` out RW+GW+BW {R,G,B} to video, possibly dimmed
- `pause_cpu` out 1 halt the core
- `dim_active` out 1 video currently dimmed
- `user_paused` out 1 user toggle latch state (for OSD/LED)

## Operation
- Button edge: `user_button` registered once; rising edge (prev 0, now 1) toggles `user_paused`. Held button toggles once only.
- Pause merge: `pause_cpu` <= `user_paused` | (|`pause_request`) | (`options[0]` & `OSD_STATUS`). Registered.
- Unpause by button: toggle to 0 clears only the user term; `pause_cpu` stays high while any other source is active.
- Dim timer, states IDLE, COUNT, DIM:
  - IDLE: prescaler and seconds counter held at 0. Go COUNT when `pause_cpu`=1 and `options[1]`=1.
  - COUNT: prescaler counts 0..TICK_CYCLES-1, wraps, on wrap seconds++. When seconds reaches DIM_SEC, go DIM.
  - DIM: `dim_active`=1, counters frozen.
  - From COUNT or DIM: `pause_cpu`=0 or `options[1]`=0 -> IDLE, counters cleared, `dim_active`=0 same transition.
- Video: `rgb_out` channel = `rgb_in` channel >> DIM_SHIFT when `dim_active`, else unchanged; per channel, zero-filled MSBs, no carry across channels.
- Prescaler width $clog2(TICK_CYCLES); seconds counter 8 bits, saturates at DIM_SEC.

## Timing
- Reset (async assert, sync-release behaviour irrelevant): `pause_cpu`=0, `user_paused`=0, `dim_active`=0, `rgb_out`=0, state IDLE, counters 0, button history 0 (a button held across reset release toggles once on first sample).
- `user_paused` changes 2 cycles after button rise at input (1 sync register + 1 latch); `pause_cpu` 1 cycle later.
- Request/OSD to `pause_cpu`: 1 cycle latency, both assert and deassert.
- `rgb_out`: 1 cycle latency from `rgb_in`; `dim_active` change takes effect on the same edge `dim_active` updates plus 1.
- Dim asserts DIM_SEC*TICK_CYCLES cycles (±1) after `pause_cpu` first observed high in IDLE.
- Simultaneous button rise and request drop: both applied same cycle; `pause_cpu` follows merged result.
- Reset mid-dim: outputs return to reset values immediately (asynchronously).

## Structure
- Shared package `pause_pkg`: state enum (IDLE/COUNT/DIM), option bit index constants (OPT_OSD=0, OPT_DIM=1).
- One sub-module natural: `pause_dimmer` — parametrised per-channel shift plus output register (RW/GW/BW/DIM_SHIFT).
- Top holds edge detect, merge, timer FSM.

## Test plan
- Reset: hold `reset_n`=0, drive `rgb_in`=6'h3F -> `rgb_out`=0, `pause_cpu`=0, `dim_active`=0.
- Button toggle: pulse `user_button` high 5 cycles, twice, 20 cycles apart -> `pause_cpu` 1 after 3 cycles, 0 after second press; no extra toggle while held.
- Merged sources (NREQ=2): user paused, raise `pause_request[1]`, press button -> `pause_cpu` stays 1 until request drops, then 0 next cycle.
- OSD gating: `OSD_STATUS`=1, `options[0]`=0 -> `pause_cpu`=0; set `options[0]`=1 -> 1 next cycle.
- Dim (TICK_CYCLES=4, DIM_SEC=3, DIM_SHIFT=1, `options[1]`=1): pause, `rgb_in`=6'b11_10_01 -> `dim_active` at 12±1 cycles, `rgb_out`=6'b01_01_00; unpause -> `dim_active`=0 and `rgb_out`=6'b11_10_01 within 2 cycles.
- Dim disabled mid-count: clear `options[1]` at cycle 8 -> counter cleared; re-enable -> full 12 cycles again before dim.
